spi_ram_ctrl: RTL and testbench
===============================

Name: spi_ram_ctrl

Overview:
- Single-port RAM with command decoder, directly downstream of the SPI slave.
- Consumes the 10-bit rx_data/rx_valid word the slave assembles and executes it as a write-address, write-data, read-address or read-data command.
- Returns the 8-bit read byte on tx_data/tx_valid, which the slave serialises onto MISO.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words.
- ADDR_SIZE, 8, address width; MEM_DEPTH must equal 2**ADDR_SIZE.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- rx_data  in  10  command word from the SPI slave: [9:8] command, [7:0] payload.
- rx_valid  in  1  rx_data valid; the slave holds it high until its frame ends.
- tx_data  out  8  read byte to the SPI slave.
- tx_valid  out  1  tx_data valid; held while the slave shifts it out.

Behaviour:
- Reset values: tx_data=0, tx_valid=0, wr_addr=0, rd_addr=0, rx_valid_q=0, state=CMD_WAIT. Memory contents are not reset.
- Command acceptance:
  - The slave holds rx_valid for many cycles, so a command is accepted only on the rising edge of rx_valid: rx_valid & ~rx_valid_q, where rx_valid_q is rx_valid registered.
  - rx_data is sampled in the same cycle as the accept.
  - Exactly one command executes per rx_valid assertion.
- Command decode on rx_data[9:8]:
  - 00 WR_ADDR: wr_addr <= rx_data[7:0].
  - 01 WR_DATA: mem[wr_addr] <= rx_data[7:0]. wr_addr is unchanged.
  - 10 RD_ADDR: rd_addr <= rx_data[7:0].
  - 11 RD_DATA: start a read of mem[rd_addr]; rx_data[7:0] is ignored.
- FSM states, with transitions evaluated each clk:
  - CMD_WAIT: accept with cmd=11 -> RD_PEND. Any other accept executes in place and stays in CMD_WAIT.
  - RD_PEND: tx_data <= mem[rd_addr] and tx_valid <= 1, both visible 1 cycle after entry. Latency from the accept edge to tx_valid is 2 clk. -> TX_HOLD.
  - TX_HOLD: tx_valid and tx_data are held stable while rx_valid=1. When rx_valid=0, clear tx_valid the next cycle -> CMD_WAIT. Any new accept is impossible here, because a rising edge requires rx_valid low first.
- tx_data retains its last value after tx_valid falls; only tx_valid qualifies it.
- Write-to-read hazard: WR_DATA to address A followed by RD_DATA at A must return the new data. Storage is written on the accept cycle, so this is satisfied by construction.
- Address width: the 8-bit payload indexes the memory directly; no wrap logic is needed because MEM_DEPTH=2**ADDR_SIZE.
- Reset mid-operation: rst_n=0 in any state forces the reset values on the next clk, including dropping tx_valid within 1 cycle. An in-flight read is abandoned.
- rx_valid high while rst_n deasserts: rx_valid_q resets to 0. If rx_valid is still 1 on the first cycle after reset, that counts as a rising edge and the command is accepted.
- Illegal or X: every 2-bit command is legal. An unknown encoding defaults to no operation, state unchanged.

Decomposition:
- shared_pkg additions:
  - typedef enum logic [1:0] cmd_t {WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11}.
  - typedef enum ram_state_t {CMD_WAIT, RD_PEND, TX_HOLD}.
- One natural sub-module: sp_ram_array, containing MEM_DEPTH x 8 storage with a synchronous write port (we, waddr, wdata) and a synchronous read port (re, raddr, rdata, 1-cycle latency).
- The decoder, edge detect, FSM and address registers remain in spi_ram_ctrl.

Test Plan:
1. Reset, then write: accept 10'h0_3C, then 10'h1_A5, then 10'h2_3C, then 10'h3_00, with each rx_valid held 12 cycles -> tx_valid rises 2 clk after the fourth accept edge with tx_data=8'hA5, holds while rx_valid=1, and falls 1 clk after rx_valid drops.
2. Held rx_valid: assert 10'h1_55 with rx_valid high for 20 cycles at wr_addr=8'h10 -> exactly one write occurs, mem[8'h10]=8'h55, and no repeated accepts.
3. Boundary addresses: write 8'h11 at 8'h00 and 8'hEE at 8'hFF, then read both -> tx_data=8'h11 and 8'hEE respectively.
4. Back-to-back overwrite: WR_ADDR 8'h40, WR_DATA 8'h01, WR_DATA 8'h02, then RD_ADDR 8'h40, RD_DATA -> tx_data=8'h02; wr_addr is not auto-incremented.
5. Reset during TX_HOLD: assert rst_n=0 for 1 cycle while tx_valid=1 -> tx_valid=0 and tx_data=0 the next clk, state=CMD_WAIT, and memory retains prior data on a subsequent read.
6. Address independence: RD_ADDR 8'h20, then WR_ADDR 8'h30, WR_DATA 8'h77, then RD_DATA -> returns mem[8'h20], not 8'h77.

Source files
------------

// File: rtl/spi_ram_ctrl_pkg.sv
// Shared types and constants for the SPI-attached RAM controller.
package spi_ram_ctrl_pkg;

  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_SIZE_DEF = 8;
  localparam int DATA_W        = 8;
  localparam int RX_W          = 10;

  // Command field carried in rx_data[9:8]
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_t;

  // Controller states
  typedef enum logic [1:0] {
    CMD_WAIT = 2'b00,
    RD_PEND  = 2'b01,
    TX_HOLD  = 2'b10
  } ram_state_t;

  // Rising-edge detect of a level held by the SPI slave for a whole frame
  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/spi_ram_ctrl_array.sv
// Single-port style storage: synchronous write, synchronous read with 1-cycle latency.
// Contents are intentionally not reset.
module spi_ram_ctrl_array
  import spi_ram_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem_r [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Write port: store wdata on an enabled cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: capture the addressed word, available the following cycle
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder and RAM for the SPI slave: executes one 10-bit command per
// rx_valid assertion and returns read bytes on tx_data/tx_valid.
module spi_ram_ctrl
  import spi_ram_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RX_W-1:0]   rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid
);

  ram_state_t           state_r,  state_s;
  logic                 rx_valid_q_r;
  logic [ADDR_SIZE-1:0] wr_addr_r, wr_addr_s;
  logic [ADDR_SIZE-1:0] rd_addr_r, rd_addr_s;
  logic [DATA_W-1:0]    tx_data_r, tx_data_s;
  logic                 tx_valid_r, tx_valid_s;
  logic                 accept_s;
  cmd_t                 cmd_s;
  logic                 mem_we_s;
  logic                 mem_re_s;
  logic [DATA_W-1:0]    mem_rdata_s;

  spi_ram_ctrl_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_addr_r),
    .wdata (rx_data[DATA_W-1:0]),
    .re    (mem_re_s),
    .raddr (rd_addr_r),
    .rdata (mem_rdata_s)
  );

  // Decode, next-state and next-output logic
  always_comb begin
    accept_s   = rise_edge(rx_valid, rx_valid_q_r);
    cmd_s      = cmd_t'(rx_data[RX_W-1:RX_W-2]);
    state_s    = state_r;
    wr_addr_s  = wr_addr_r;
    rd_addr_s  = rd_addr_r;
    tx_data_s  = tx_data_r;
    tx_valid_s = tx_valid_r;
    mem_we_s   = 1'b0;
    mem_re_s   = 1'b0;
    case (state_r)
      CMD_WAIT: begin
        if (accept_s) begin
          case (cmd_s)
            WR_ADDR: wr_addr_s = rx_data[ADDR_SIZE-1:0];
            WR_DATA: mem_we_s  = 1'b1;
            RD_ADDR: rd_addr_s = rx_data[ADDR_SIZE-1:0];
            RD_DATA: begin
              // Read issued on the accept cycle; data lands one cycle later
              mem_re_s = 1'b1;
              state_s  = RD_PEND;
            end
            default: state_s = state_r;
          endcase
        end else begin
          state_s = CMD_WAIT;
        end
      end
      RD_PEND: begin
        tx_data_s  = mem_rdata_s;
        tx_valid_s = 1'b1;
        state_s    = TX_HOLD;
      end
      TX_HOLD: begin
        // Hold the byte while the slave is still shifting it out
        if (!rx_valid) begin
          tx_valid_s = 1'b0;
          state_s    = CMD_WAIT;
        end else begin
          tx_valid_s = 1'b1;
        end
      end
      default: begin
        tx_valid_s = 1'b0;
        state_s    = CMD_WAIT;
      end
    endcase
  end

  // State, address and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= CMD_WAIT;
      rx_valid_q_r <= 1'b0;
      wr_addr_r    <= {ADDR_SIZE{1'b0}};
      rd_addr_r    <= {ADDR_SIZE{1'b0}};
      tx_data_r    <= {DATA_W{1'b0}};
      tx_valid_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      rx_valid_q_r <= rx_valid;
      wr_addr_r    <= wr_addr_s;
      rd_addr_r    <= rd_addr_s;
      tx_data_r    <= tx_data_s;
      tx_valid_r   <= tx_valid_s;
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl.
`timescale 1ns/1ps
module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int tests;
  int fails;

  spi_ram_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold one command for 'hold' cycles, then one idle cycle
  task automatic send_cmd(input logic [9:0] word, input int hold);
    rx_data  = word;
    rx_valid = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issue RD_DATA held for 'hold' cycles and report what tx showed at key points
  task automatic issue_read(input int hold,
                            output logic v_acc,
                            output logic v_lat, output logic [7:0] d_lat,
                            output logic v_hold, output logic [7:0] d_hold,
                            output logic v_drop, output logic [7:0] d_drop);
    rx_data  = 10'h300;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    v_acc = tx_valid;
    @(posedge clk); #1;
    v_lat = tx_valid;
    d_lat = tx_data;
    repeat (hold - 2) begin @(posedge clk); #1; end
    v_hold = tx_valid;
    d_hold = tx_data;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    v_drop = tx_valid;
    d_drop = tx_data;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 10'h000;
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_tx_valid: got %b expected %b", tx_valid, 1'b0);
    end
    tests++;
    if (tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_tx_data: got %h expected %h", tx_data, 8'h00);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_rw();
    logic       va, vl, vh, vd;
    logic [7:0] dl, dh, dd;
    send_cmd(10'h03C, 12);
    send_cmd(10'h1A5, 12);
    send_cmd(10'h23C, 12);
    issue_read(12, va, vl, dl, vh, dh, vd, dd);
    tests++;
    if (va !== 1'b0) begin
      fails++;
      $display("FAIL basic_valid_early: got %b expected %b", va, 1'b0);
    end
    tests++;
    if (vl !== 1'b1 || dl !== 8'hA5) begin
      fails++;
      $display("FAIL basic_latency: got valid=%b data=%h expected valid=1 data=a5", vl, dl);
    end
    tests++;
    if (vh !== 1'b1 || dh !== 8'hA5) begin
      fails++;
      $display("FAIL basic_hold: got valid=%b data=%h expected valid=1 data=a5", vh, dh);
    end
    tests++;
    if (vd !== 1'b0 || dd !== 8'hA5) begin
      fails++;
      $display("FAIL basic_drop: got valid=%b data=%h expected valid=0 data=a5", vd, dd);
    end
  endtask

  task automatic test_held_valid();
    logic       va, vl, vh, vd;
    logic [7:0] dl, dh, dd;
    logic       saw_tx;
    send_cmd(10'h010, 4);
    rx_data  = 10'h155;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    // Payload changes mid-frame: a repeated accept would store 66
    rx_data = 10'h166;
    saw_tx  = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
      if (tx_valid === 1'b1) saw_tx = 1'b1;
    end
    rx_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (saw_tx !== 1'b0) begin
      fails++;
      $display("FAIL held_no_tx: got tx_valid seen=%b expected %b", saw_tx, 1'b0);
    end
    send_cmd(10'h210, 4);
    issue_read(4, va, vl, dl, vh, dh, vd, dd);
    tests++;
    if (vl !== 1'b1 || dl !== 8'h55) begin
      fails++;
      $display("FAIL held_single_write: got valid=%b data=%h expected valid=1 data=55", vl, dl);
    end
  endtask

  task automatic test_boundary();
    logic       va, vl, vh, vd;
    logic [7:0] dl, dh, dd;
    send_cmd(10'h000, 3);
    send_cmd(10'h111, 3);
    send_cmd(10'h0FF, 3);
    send_cmd(10'h1EE, 3);
    send_cmd(10'h200, 3);
    issue_read(4, va, vl, dl, vh, dh, vd, dd);
    tests++;
    if (vl !== 1'b1 || dl !== 8'h11) begin
      fails++;
      $display("FAIL boundary_addr00: got valid=%b data=%h expected valid=1 data=11", vl, dl);
    end
    send_cmd(10'h2FF, 3);
    issue_read(4, va, vl, dl, vh, dh, vd, dd);
    tests++;
    if (vl !== 1'b1 || dl !== 8'hEE) begin
      fails++;
      $display("FAIL boundary_addrff: got valid=%b data=%h expected valid=1 data=ee", vl, dl);
    end
  endtask

  task automatic test_back_to_back();
    logic       va, vl, vh, vd;
    logic [7:0] dl, dh, dd;
    send_cmd(10'h041, 3);
    send_cmd(10'h15A, 3);
    send_cmd(10'h040, 3);
    send_cmd(10'h101, 3);
    send_cmd(10'h102, 3);
    send_cmd(10'h240, 3);
    issue_read(4, va, vl, dl, vh, dh, vd, dd);
    tests++;
    if (vl !== 1'b1 || dl !== 8'h02) begin
      fails++;
      $display("FAIL b2b_overwrite: got valid=%b data=%h expected valid=1 data=02", vl, dl);
    end
    send_cmd(10'h241, 3);
    issue_read(4, va, vl, dl, vh, dh, vd, dd);
    tests++;
    if (vl !== 1'b1 || dl !== 8'h5A) begin
      fails++;
      $display("FAIL b2b_no_incr: got valid=%b data=%h expected valid=1 data=5a", vl, dl);
    end
  endtask

  task automatic test_addr_independence();
    logic       va, vl, vh, vd;
    logic [7:0] dl, dh, dd;
    send_cmd(10'h020, 3);
    send_cmd(10'h199, 3);
    send_cmd(10'h220, 3);
    send_cmd(10'h030, 3);
    send_cmd(10'h177, 3);
    issue_read(4, va, vl, dl, vh, dh, vd, dd);
    tests++;
    if (vl !== 1'b1 || dl !== 8'h99) begin
      fails++;
      $display("FAIL indep_rd_addr: got valid=%b data=%h expected valid=1 data=99", vl, dl);
    end
    send_cmd(10'h230, 3);
    issue_read(4, va, vl, dl, vh, dh, vd, dd);
    tests++;
    if (vl !== 1'b1 || dl !== 8'h77) begin
      fails++;
      $display("FAIL indep_wr_data: got valid=%b data=%h expected valid=1 data=77", vl, dl);
    end
  endtask

  task automatic test_reset_in_hold();
    logic       va, vl, vh, vd;
    logic [7:0] dl, dh, dd;
    send_cmd(10'h2FF, 3);
    rx_data  = 10'h300;
    rx_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin
      fails++;
      $display("FAIL rst_hold_pre: got valid=%b data=%h expected valid=1 data=ee", tx_valid, tx_data);
    end
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL rst_hold_clear: got valid=%b data=%h expected valid=0 data=00", tx_valid, tx_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // rd_addr is back at 0; memory must still hold 11 there
    issue_read(4, va, vl, dl, vh, dh, vd, dd);
    tests++;
    if (va !== 1'b0 || vl !== 1'b1 || dl !== 8'h11) begin
      fails++;
      $display("FAIL rst_hold_retain: got early=%b valid=%b data=%h expected early=0 valid=1 data=11", va, vl, dl);
    end
  endtask

  task automatic test_reset_with_valid();
    send_cmd(10'h2FF, 3);
    rst_n    = 1'b0;
    rx_data  = 10'h300;
    rx_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid_early: got %b expected %b", tx_valid, 1'b0);
    end
    @(posedge clk); #1;
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
      fails++;
      $display("FAIL rst_valid_accept: got valid=%b data=%h expected valid=1 data=11", tx_valid, tx_data);
    end
    rx_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid_drop: got %b expected %b", tx_valid, 1'b0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic_rw();
    test_held_valid();
    test_boundary();
    test_back_to_back();
    test_addr_independence();
    test_reset_in_hold();
    test_reset_with_valid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
